exu_wbck: RTL and testbench
===========================

# exu_wbck

Writeback/commit stage directly downstream of the regular-ALU issue path. It accepts one ALU result per cycle through a valid/ready handshake into a 2-entry buffer. It retires results in order through a commit handshake and writes the register file on each retire. It counts retired instructions and halts the core once an `ebreak` retires.

## Interface
Parameters:
- `XLEN`, 32: data/PC width.
- `RFIDX_WIDTH`, 5: register index width.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wbck_i_valid`  in  1  ALU result valid.
- `wbck_i_ready`  out  1  stage can accept a result.
- `wbck_i_wdat`  in  XLEN  result data (ALU writeback data).
- `wbck_i_rdidx`  in  RFIDX_WIDTH  destination register index.
- `wbck_i_rdwen`  in  1  instruction writes rd.
- `wbck_i_pc`  in  XLEN  instruction PC.
- `wbck_i_ebreak`  in  1  instruction is `ebreak` (ALU commit-ebreak flag).
- `cmt_o_valid`  out  1  head entry ready to retire.
- `cmt_o_ready`  in  1  commit consumer accepts.
- `cmt_o_pc`  out  XLEN  PC of head entry.
- `cmt_o_ebreak`  out  1  head entry is `ebreak`.
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  RFIDX_WIDTH  write index.
- `rf_wdat`  out  XLEN  write data.
- `minstret`  out  64  retired-instruction count.
- `halt`  out  1  core halted after `ebreak` retire.

## Operation
- Buffer: 2-entry in-order FIFO of {wdat, rdidx, rdwen, pc, ebreak}. It has a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2).
- Push happens when `wbck_i_valid & wbck_i_ready`. Pop happens when `cmt_o_valid & cmt_o_ready` (retire).
- `wbck_i_ready` = (count != 2) & (state == RUN). It depends only on registers, never on `cmt_o_ready`.
- `cmt_o_valid` = (count != 0) & (state != HALT). `cmt_o_pc`, `cmt_o_ebreak`, `rf_waddr` and `rf_wdat` all come from the head entry.
- `rf_wen` = retire & head.rdwen & (head.rdidx != 0). Writes to x0 are suppressed. `rf_wen` is 0 whenever there is no retire.
- `minstret` increments by 1 on every retire, including `ebreak`. It wraps from 2^64-1 to 0.
- State machine:
  - RUN: normal operation. A push with `wbck_i_ebreak=1` moves to DRAIN.
  - DRAIN: no new pushes. Entries retire normally. Retiring the ebreak entry moves to HALT.
  - HALT: `halt`=1. Count is cleared to 0. All handshakes are deasserted. Only `rst` leaves HALT.
- Entries accepted after an `ebreak` cannot exist, because ready drops in DRAIN.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count 1. At count 0 there is no pop; at count 2 there is no push.

## Timing
- Reset (when `rst`=1 at a clock edge): count=0, pointers=0, state=RUN, `minstret`=0. Outputs after reset: `wbck_i_ready`=1, `cmt_o_valid`=0, `rf_wen`=0, `halt`=0. `cmt_o_pc`, `rf_waddr`, `rf_wdat` and `cmt_o_ebreak` read 0 because the entry storage is reset.
- Reset mid-operation discards all buffered entries; nothing retires in the reset cycle.
- Latency: a result pushed at edge N is visible on `cmt_o_*` after edge N. It can retire (and write the RF) in the cycle following the push edge.
- Throughput: 1 retire per cycle while `cmt_o_ready` is held at 1.
- With `cmt_o_ready`=0, the stage absorbs 2 results and then deasserts `wbck_i_ready`.
- `rf_wen`, `rf_waddr` and `rf_wdat` are combinational from head and retire. The RF samples them on the same edge as the pop.
- `halt` rises on the edge where the ebreak entry retires. `minstret` already includes that `ebreak` in the same cycle `halt` reads 1.
- Handshake rules: the producer must hold `wbck_i_*` stable while valid and not ready. The stage holds `cmt_o_*` stable while `cmt_o_valid & ~cmt_o_ready`.

## Test plan
- Back-to-back stream, `cmt_o_ready`=1: push rd=x5 0x11, rd=x6 0x22, rd=x7 0x33 on consecutive cycles. Required: `rf_wen` on three consecutive cycles starting one cycle after the first push, with (5,0x11), (6,0x22), (7,0x33). `minstret` ends at 3. `wbck_i_ready` stays 1.
- Backpressure: `cmt_o_ready`=0, push 3 results. Required: `wbck_i_ready`=0 after the 2nd push and the 3rd is held off. Then release `cmt_o_ready`: results retire in push order and the 3rd is accepted on the cycle after the first pop.
- x0 / no-rd: retire rdidx=0 with rdwen=1, then rdidx=3 with rdwen=0. Required: `rf_wen`=0 both times and `minstret` increments by 2.
- Ebreak: push add (rd=x1, 0x5), `ebreak` pc=0x80000010, then hold a further valid. Required: the further valid is never accepted. The add retires, then `cmt_o_ebreak`=1 with pc 0x80000010 retires. `halt`=1 from the next cycle with `minstret`=2, and `cmt_o_valid`/`wbck_i_ready` stay 0.
- Reset mid-stream: 2 entries buffered with `cmt_o_ready`=0, then assert `rst` for 1 cycle. Required: count=0, no `rf_wen`, `minstret`=0, `halt`=0 afterwards. A new push retires normally.
- Reset from HALT: after the ebreak test, pulse `rst`. Required: state RUN, `wbck_i_ready`=1, `halt`=0.

Source files
------------

// File: rtl/exu_wbck.sv
// Writeback/commit stage: 2-entry in-order buffer between the ALU and retire,
// driving register-file writes, the retired-instruction counter and ebreak halt.
module exu_wbck #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wbck_i_valid,
   output logic                   wbck_i_ready,
   input  logic [XLEN-1:0]        wbck_i_wdat,
   input  logic [RFIDX_WIDTH-1:0] wbck_i_rdidx,
   input  logic                   wbck_i_rdwen,
   input  logic [XLEN-1:0]        wbck_i_pc,
   input  logic                   wbck_i_ebreak,
   output logic                   cmt_o_valid,
   input  logic                   cmt_o_ready,
   output logic [XLEN-1:0]        cmt_o_pc,
   output logic                   cmt_o_ebreak,
   output logic                   rf_wen,
   output logic [RFIDX_WIDTH-1:0] rf_waddr,
   output logic [XLEN-1:0]        rf_wdat,
   output logic [63:0]            minstret,
   output logic                   halt
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   logic                   wptr_q, wptr_d;
   logic                   rptr_q, rptr_d;
   logic [63:0]            minstret_q, minstret_d;

   logic [XLEN-1:0]        wdat_q   [2];
   logic [RFIDX_WIDTH-1:0] rdidx_q  [2];
   logic                   rdwen_q  [2];
   logic [XLEN-1:0]        pc_q     [2];
   logic                   ebreak_q [2];

   logic push;
   logic pop;
   logic head_rdwen;
   logic head_ebreak;

   assign push        = wbck_i_valid & wbck_i_ready;
   assign pop         = cmt_o_valid & cmt_o_ready;
   assign head_rdwen  = rdwen_q[rptr_q];
   assign head_ebreak = ebreak_q[rptr_q];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: ebreak acceptance stops intake, its retire halts the core
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (push && wbck_i_ebreak) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && head_ebreak)    state_d = ST_HALT;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RUN;
      endcase
   end

   // Output logic: handshakes depend only on registered state
   always_comb begin
      wbck_i_ready = (cnt_q != 2'd2) && (state_q == ST_RUN);
      cmt_o_valid  = (cnt_q != 2'd0) && (state_q != ST_HALT);
      halt         = (state_q == ST_HALT);
   end

   always_comb begin
      wptr_d     = wptr_q ^ push;
      rptr_d     = rptr_q ^ pop;
      minstret_d = minstret_q + {63'd0, pop};
      if (state_d == ST_HALT) begin
         cnt_d = 2'd0;
      end else begin
         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 2'd0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         minstret_q <= 64'd0;
      end else begin
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         minstret_q <= minstret_d;
      end
   end

   // Entry storage is cleared on reset so head-derived outputs read zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wdat_q[i]   <= '0;
            rdidx_q[i]  <= '0;
            rdwen_q[i]  <= 1'b0;
            pc_q[i]     <= '0;
            ebreak_q[i] <= 1'b0;
         end
      end else if (push) begin
         wdat_q[wptr_q]   <= wbck_i_wdat;
         rdidx_q[wptr_q]  <= wbck_i_rdidx;
         rdwen_q[wptr_q]  <= wbck_i_rdwen;
         pc_q[wptr_q]     <= wbck_i_pc;
         ebreak_q[wptr_q] <= wbck_i_ebreak;
      end
   end

   assign cmt_o_pc     = pc_q[rptr_q];
   assign cmt_o_ebreak = head_ebreak;
   assign rf_waddr     = rdidx_q[rptr_q];
   assign rf_wdat      = wdat_q[rptr_q];
   assign rf_wen       = pop && head_rdwen && (rdidx_q[rptr_q] != '0);
   assign minstret     = minstret_q;

endmodule

// File: tb/tb_exu_wbck.sv
// Directed self-checking bench for exu_wbck.
module tb_exu_wbck;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbck_i_valid;
   logic        wbck_i_ready;
   logic [31:0] wbck_i_wdat;
   logic [4:0]  wbck_i_rdidx;
   logic        wbck_i_rdwen;
   logic [31:0] wbck_i_pc;
   logic        wbck_i_ebreak;
   logic        cmt_o_valid;
   logic        cmt_o_ready;
   logic [31:0] cmt_o_pc;
   logic        cmt_o_ebreak;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdat;
   logic [63:0] minstret;
   logic        halt;

   int checks   = 0;
   int failures = 0;

   exu_wbck #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .wbck_i_valid(wbck_i_valid), .wbck_i_ready(wbck_i_ready),
      .wbck_i_wdat(wbck_i_wdat), .wbck_i_rdidx(wbck_i_rdidx),
      .wbck_i_rdwen(wbck_i_rdwen), .wbck_i_pc(wbck_i_pc),
      .wbck_i_ebreak(wbck_i_ebreak),
      .cmt_o_valid(cmt_o_valid), .cmt_o_ready(cmt_o_ready),
      .cmt_o_pc(cmt_o_pc), .cmt_o_ebreak(cmt_o_ebreak),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdat(rf_wdat),
      .minstret(minstret), .halt(halt)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are changed and outputs read here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                        input logic [31:0] dat, input logic [31:0] pc, input logic eb);
      wbck_i_valid  = v;
      wbck_i_rdidx  = rd;
      wbck_i_rdwen  = wen;
      wbck_i_wdat   = dat;
      wbck_i_pc     = pc;
      wbck_i_ebreak = eb;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmt_o_ready = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (wbck_i_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wbck_i_ready); end
      checks++; if (cmt_o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmt_o_valid); end
      checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
      checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt); end
      checks++; if (minstret !== 64'd0) begin failures++; $display("FAIL reset_minstret got=%0d exp=0", minstret); end
      checks++; if ({cmt_o_pc, rf_wdat, rf_waddr, cmt_o_ebreak} !== 70'd0) begin
         failures++; $display("FAIL reset_head pc=%h wdat=%h waddr=%0d eb=%b exp=all zero", cmt_o_pc, rf_wdat, rf_waddr, cmt_o_ebreak);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rds  [3] = '{5'd5, 5'd6, 5'd7};
      logic [31:0] dats [3] = '{32'h11, 32'h22, 32'h33};
      cmt_o_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, rds[i], 1'b1, dats[i], 32'h100 + 32'(4*i), 1'b0);
         else       drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
         #1;
         if (i < 3) begin
            checks++; if (wbck_i_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, wbck_i_ready); end
         end
         if (i > 0) begin
            checks++;
            if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, rds[i-1], dats[i-1]}) begin
               failures++; $display("FAIL b2b_rf[%0d] got wen=%b addr=%0d dat=%h exp wen=1 addr=%0d dat=%h", i-1, rf_wen, rf_waddr, rf_wdat, rds[i-1], dats[i-1]);
            end
         end else begin
            checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL b2b_rf_early got=%b exp=0", rf_wen); end
         end
         tick();
      end
      checks++; if (rf_wen !== 1'b0 || cmt_o_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle wen=%b valid=%b exp=0,0", rf_wen, cmt_o_valid); end
      checks++; if (minstret !== 64'd3) begin failures++; $display("FAIL b2b_minstret got=%0d exp=3", minstret); end
   endtask

   task automatic test_backpressure();
      cmt_o_ready = 1'b0;
      drive(1'b1, 5'd8, 1'b1, 32'hA, 32'h200, 1'b0);
      tick();
      drive(1'b1, 5'd9, 1'b1, 32'hB, 32'h204, 1'b0);
      tick();
      checks++; if (wbck_i_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", wbck_i_ready); end
      drive(1'b1, 5'd10, 1'b1, 32'hC, 32'h208, 1'b0);
      tick();
      checks++; if (wbck_i_ready !== 1'b0) begin failures++; $display("FAIL bp_held_off got=%b exp=0", wbck_i_ready); end
      checks++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h200) begin failures++; $display("FAIL bp_head valid=%b pc=%h exp 1/200", cmt_o_valid, cmt_o_pc); end
      checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL bp_no_wen got=%b exp=0", rf_wen); end
      cmt_o_ready = 1'b1;
      #1;
      checks++; if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, 5'd8, 32'hA}) begin failures++; $display("FAIL bp_pop1 wen=%b addr=%0d dat=%h exp 1/8/a", rf_wen, rf_waddr, rf_wdat); end
      tick();
      checks++; if (wbck_i_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", wbck_i_ready); end
      checks++; if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, 5'd9, 32'hB}) begin failures++; $display("FAIL bp_pop2 wen=%b addr=%0d dat=%h exp 1/9/b", rf_wen, rf_waddr, rf_wdat); end
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if ({rf_wen, rf_waddr, rf_wdat, cmt_o_pc} !== {1'b1, 5'd10, 32'hC, 32'h208}) begin failures++; $display("FAIL bp_pop3 wen=%b addr=%0d dat=%h pc=%h exp 1/10/c/208", rf_wen, rf_waddr, rf_wdat, cmt_o_pc); end
      tick();
      checks++; if (cmt_o_valid !== 1'b0 || minstret !== 64'd6) begin failures++; $display("FAIL bp_end valid=%b minstret=%0d exp 0/6", cmt_o_valid, minstret); end
   endtask

   task automatic test_x0_nord();
      cmt_o_ready = 1'b1;
      drive(1'b1, 5'd0, 1'b1, 32'h55, 32'h300, 1'b0);
      tick();
      drive(1'b1, 5'd3, 1'b0, 32'h66, 32'h304, 1'b0);
      #1;
      checks++; if (cmt_o_valid !== 1'b1 || rf_wen !== 1'b0) begin failures++; $display("FAIL x0_suppress valid=%b wen=%b exp 1/0", cmt_o_valid, rf_wen); end
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if (cmt_o_valid !== 1'b1 || rf_wen !== 1'b0) begin failures++; $display("FAIL nord_suppress valid=%b wen=%b exp 1/0", cmt_o_valid, rf_wen); end
      tick();
      checks++; if (minstret !== 64'd8) begin failures++; $display("FAIL x0_minstret got=%0d exp=8", minstret); end
   endtask

   task automatic test_reset_midstream();
      cmt_o_ready = 1'b0;
      drive(1'b1, 5'd11, 1'b1, 32'h44, 32'h400, 1'b0);
      tick();
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmt_o_ready = 1'b1;
      #1;
      checks++; if (cmt_o_valid !== 1'b0 || rf_wen !== 1'b0) begin failures++; $display("FAIL midrst_empty valid=%b wen=%b exp 0/0", cmt_o_valid, rf_wen); end
      checks++; if (minstret !== 64'd0 || halt !== 1'b0 || wbck_i_ready !== 1'b1) begin failures++; $display("FAIL midrst_state minstret=%0d halt=%b ready=%b exp 0/0/1", minstret, halt, wbck_i_ready); end
      drive(1'b1, 5'd12, 1'b1, 32'h77, 32'h500, 1'b0);
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, 5'd12, 32'h77}) begin failures++; $display("FAIL midrst_push wen=%b addr=%0d dat=%h exp 1/12/77", rf_wen, rf_waddr, rf_wdat); end
      tick();
      checks++; if (minstret !== 64'd1) begin failures++; $display("FAIL midrst_minstret got=%0d exp=1", minstret); end
   endtask

   task automatic test_ebreak();
      rst = 1'b1;
      cmt_o_ready = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b1, 5'd1, 1'b1, 32'h5, 32'h8000_000C, 1'b0);
      tick();
      drive(1'b1, 5'd0, 1'b0, 32'h0, 32'h8000_0010, 1'b1);
      #1;
      checks++; if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, 5'd1, 32'h5}) begin failures++; $display("FAIL eb_add wen=%b addr=%0d dat=%h exp 1/1/5", rf_wen, rf_waddr, rf_wdat); end
      tick();
      drive(1'b1, 5'd2, 1'b1, 32'h99, 32'h8000_0014, 1'b0);
      #1;
      checks++; if (wbck_i_ready !== 1'b0) begin failures++; $display("FAIL eb_drain_ready got=%b exp=0", wbck_i_ready); end
      checks++; if ({cmt_o_valid, cmt_o_ebreak, cmt_o_pc} !== {1'b1, 1'b1, 32'h8000_0010}) begin failures++; $display("FAIL eb_head valid=%b eb=%b pc=%h exp 1/1/80000010", cmt_o_valid, cmt_o_ebreak, cmt_o_pc); end
      checks++; if (rf_wen !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL eb_retire wen=%b halt=%b exp 0/0", rf_wen, halt); end
      tick();
      checks++; if (halt !== 1'b1 || minstret !== 64'd2) begin failures++; $display("FAIL eb_halt halt=%b minstret=%0d exp 1/2", halt, minstret); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cmt_o_valid !== 1'b0 || wbck_i_ready !== 1'b0 || rf_wen !== 1'b0 || halt !== 1'b1 || minstret !== 64'd2) begin
            failures++; $display("FAIL eb_hold[%0d] valid=%b ready=%b wen=%b halt=%b minstret=%0d exp 0/0/0/1/2", i, cmt_o_valid, wbck_i_ready, rf_wen, halt, minstret);
         end
         tick();
      end
   endtask

   task automatic test_reset_from_halt();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (halt !== 1'b0 || wbck_i_ready !== 1'b1 || cmt_o_valid !== 1'b0 || minstret !== 64'd0) begin
         failures++; $display("FAIL halt_rst halt=%b ready=%b valid=%b minstret=%0d exp 0/1/0/0", halt, wbck_i_ready, cmt_o_valid, minstret);
      end
      drive(1'b1, 5'd4, 1'b1, 32'hBEEF, 32'h600, 1'b0);
      tick();
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if ({rf_wen, rf_waddr, rf_wdat} !== {1'b1, 5'd4, 32'hBEEF}) begin failures++; $display("FAIL halt_rst_push wen=%b addr=%0d dat=%h exp 1/4/beef", rf_wen, rf_waddr, rf_wdat); end
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_x0_nord();
      test_reset_midstream();
      test_ebreak();
      test_reset_from_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
